// File: rtl/uart_fifo_transceiver.sv
// uart_fifo_transceiver: FIFO-buffered UART with 16x oversampled RX, parity/stop options, sticky errors and loopback
module uart_fifo_sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  // a pop frees the slot in the same cycle, so a full FIFO may still take a push
  assign do_push = push & (~full | pop);
  assign do_pop = pop & ~empty;
  assign rdata = mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
    end
  end
  always_ff @(posedge clk) if (do_push) mem[wp[AW-1:0]] <= wdata;
endmodule

module uart_fifo_transceiver #(
  parameter int DATA_W = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic              cfg_parity_en,
  input  logic              cfg_parity_odd,
  input  logic              cfg_stop2,
  input  logic              cfg_loopback,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              serial_tx,
  input  logic              serial_rx,
  output logic              tx_busy,
  output logic              rx_busy,
  input  logic              err_clr,
  output logic              parity_err,
  output logic              framing_err,
  output logic              overrun_err
);
  localparam logic [3:0] LAST = 4'(DATA_W - 1);
  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP1, T_STOP2} tx_state_t;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP} rx_state_t;
  tx_state_t tx_state, tx_next;
  rx_state_t rx_state, rx_next;
  logic [DIV_W-1:0] div_cnt;
  logic tick;
  logic [DATA_W-1:0] tx_head, tx_sh, rx_sh, rx_head;
  logic tx_full, tx_empty, tx_pop, tx_line, tx_done, tx_par, tx_par_en, tx_stop2;
  logic [3:0] tx_cnt, tx_bit, rx_cnt, rx_bit;
  logic rx_full, rx_empty, rx_pop, rx_push, rx_done, rx_mid, rx_s, rx_fall, rx_par_bad;
  logic [2:0] rx_sr;
  logic set_pe, set_fe, set_oe;
  assign tick = div_cnt == baud_div;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) div_cnt <= '0;
    else div_cnt <= tick ? '0 : div_cnt + 1'b1;
  end
  uart_fifo_sync_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_valid & tx_ready), .pop(tx_pop), .wdata(tx_data),
    .rdata(tx_head), .full(tx_full), .empty(tx_empty)
  );
  assign tx_ready = ~tx_full;
  assign tx_busy = tx_state != T_IDLE;
  assign tx_done = tick && tx_cnt == 4'd15;
  assign serial_tx = cfg_loopback | tx_line;
  always_comb begin
    tx_next = tx_state;
    tx_pop = 1'b0;
    tx_line = 1'b1;
    case (tx_state)
      T_IDLE: begin
        tx_pop = ~tx_empty;
        tx_next = tx_empty ? T_IDLE : T_START;
      end
      T_START: begin
        tx_line = 1'b0;
        if (tx_done) tx_next = T_DATA;
      end
      T_DATA: begin
        tx_line = tx_sh[0];
        if (tx_done && tx_bit == LAST) tx_next = tx_par_en ? T_PAR : T_STOP1;
      end
      T_PAR: begin
        tx_line = tx_par;
        if (tx_done) tx_next = T_STOP1;
      end
      T_STOP1, T_STOP2: if (tx_done) begin
        // the last stop bit re-pops directly so back-to-back frames have no idle gap
        if (tx_state == T_STOP1 && tx_stop2) tx_next = T_STOP2;
        else begin
          tx_pop = ~tx_empty;
          tx_next = tx_empty ? T_IDLE : T_START;
        end
      end
      default: tx_next = T_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= T_IDLE;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh <= '0;
      tx_par <= 1'b0;
      tx_par_en <= 1'b0;
      tx_stop2 <= 1'b0;
    end else begin
      tx_state <= tx_next;
      if (tx_pop) begin
        tx_sh <= tx_head;
        tx_par <= ^tx_head ^ cfg_parity_odd;
        tx_par_en <= cfg_parity_en;
        tx_stop2 <= cfg_stop2;
        tx_cnt <= '0;
        tx_bit <= '0;
      end else if (tick) begin
        tx_cnt <= tx_cnt + 4'd1;
        if (tx_done && tx_state == T_DATA) begin
          tx_sh <= tx_sh >> 1;
          tx_bit <= tx_bit + 4'd1;
        end
      end
    end
  end
  // two synchronizer stages plus one history stage for falling-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rx_sr <= 3'b111;
    else rx_sr <= {rx_sr[1:0], cfg_loopback ? tx_line : serial_rx};
  end
  assign rx_s = rx_sr[1];
  assign rx_fall = rx_sr[2] & ~rx_sr[1];
  assign rx_done = tick && rx_cnt == 4'd15;
  assign rx_mid = tick && rx_cnt == 4'd7;
  assign rx_busy = rx_state != R_IDLE;
  assign rx_valid = ~rx_empty;
  assign rx_pop = rx_valid & rx_ready;
  assign rx_data = rx_empty ? '0 : rx_head;
  uart_fifo_sync_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .wdata(rx_sh),
    .rdata(rx_head), .full(rx_full), .empty(rx_empty)
  );
  always_comb begin
    rx_next = rx_state;
    rx_push = 1'b0;
    set_pe = 1'b0;
    set_fe = 1'b0;
    set_oe = 1'b0;
    case (rx_state)
      R_IDLE: if (rx_fall) rx_next = R_START;
      R_START: if (rx_mid) rx_next = rx_s ? R_IDLE : R_DATA;
      R_DATA: if (rx_done && rx_bit == LAST) rx_next = cfg_parity_en ? R_PAR : R_STOP;
      R_PAR: if (rx_done) rx_next = R_STOP;
      R_STOP: if (rx_done) begin
        rx_next = R_IDLE;
        set_fe = ~rx_s;
        set_oe = rx_s & rx_full & ~rx_pop;
        rx_push = rx_s & (~rx_full | rx_pop);
        set_pe = rx_push & rx_par_bad;
      end
      default: rx_next = R_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state <= R_IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh <= '0;
      rx_par_bad <= 1'b0;
    end else begin
      rx_state <= rx_next;
      if (rx_state == R_IDLE) begin
        rx_cnt <= '0;
        rx_bit <= '0;
        rx_par_bad <= 1'b0;
      end else if (tick) begin
        rx_cnt <= (rx_state == R_START && rx_cnt == 4'd7) ? 4'd0 : rx_cnt + 4'd1;
        if (rx_done && rx_state == R_DATA) begin
          rx_sh <= {rx_s, rx_sh[DATA_W-1:1]};
          rx_bit <= rx_bit + 4'd1;
        end
        if (rx_done && rx_state == R_PAR) rx_par_bad <= rx_s ^ (^rx_sh) ^ cfg_parity_odd;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_err <= 1'b0;
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      parity_err <= set_pe | (parity_err & ~err_clr);
      framing_err <= set_fe | (framing_err & ~err_clr);
      overrun_err <= set_oe | (overrun_err & ~err_clr);
    end
  end
endmodule

// File: tb/tb_uart_fifo_transceiver.sv
// tb_uart_fifo_transceiver: directed stimulus with a queue scoreboard checked by an independent RX monitor
module tb_uart_fifo_transceiver;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [15:0] baud_div = '0;
  logic cfg_parity_en = 0, cfg_parity_odd = 0, cfg_stop2 = 0, cfg_loopback = 0;
  logic [7:0] tx_data = '0;
  logic tx_valid = 0, rx_ready = 1, err_clr = 0;
  logic tx_ready, rx_valid, serial_tx, serial_rx, tx_busy, rx_busy;
  logic parity_err, framing_err, overrun_err;
  logic [7:0] rx_data;
  logic link = 0, rx_drv = 1, lb_watch = 0, lb_bad = 0;
  logic [7:0] q[$];
  logic [7:0] e;
  logic [11:0] fb;
  int total = 0, bad = 0, n, acc;

  assign serial_rx = link ? serial_tx : rx_drv;
  always #5 clk = ~clk;

  uart_fifo_transceiver dut (
    .clk(clk), .rst(rst), .baud_div(baud_div), .cfg_parity_en(cfg_parity_en),
    .cfg_parity_odd(cfg_parity_odd), .cfg_stop2(cfg_stop2), .cfg_loopback(cfg_loopback),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .serial_tx(serial_tx), .serial_rx(serial_rx),
    .tx_busy(tx_busy), .rx_busy(rx_busy), .err_clr(err_clr), .parity_err(parity_err),
    .framing_err(framing_err), .overrun_err(overrun_err)
  );

  always @(negedge clk) begin
    if (lb_watch && serial_tx !== 1'b1) lb_bad = 1'b1;
    if (rst && rx_valid && rx_ready) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL rx_unexpected got=%h exp=none", rx_data);
      end else begin
        e = q.pop_front();
        if (rx_data !== e) begin
          bad++;
          $display("FAIL rx_data got=%h exp=%h", rx_data, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_data = b;
    tx_valid = 1'b1;
    cyc(1);
    tx_valid = 1'b0;
  endtask

  task automatic drain(input int lim);
    for (int i = 0; i < lim && !(q.size() == 0 && !tx_busy && !rx_busy); i++) cyc(1);
    chk("drain_queue_empty", q.size(), 0);
  endtask

  task automatic clr_err();
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
  endtask

  task automatic send_bits(input logic [10:0] bits, input int nb);
    for (int k = 0; k < nb; k++) begin
      rx_drv = bits[k];
      cyc(16);
    end
    rx_drv = 1'b1;
  endtask

  initial begin
    cyc(3);
    chk("rst_serial_tx", serial_tx, 1);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_busy", {tx_busy, rx_busy}, 0);
    chk("rst_errs", {parity_err, framing_err, overrun_err}, 0);
    chk("rst_rx_data", rx_data, 0);
    rst = 1'b1;
    cyc(2);

    // loopback 8N1 latency
    cfg_loopback = 1'b1;
    lb_watch = 1'b1;
    q.push_back(8'hA5);
    push_tx(8'hA5);
    n = 0;
    while (!rx_valid && n < 400) begin
      cyc(1);
      n++;
    end
    chk("lb_latency_in_range", (n >= 153 && n <= 156), 1);
    if (n < 153 || n > 156) $display("FAIL lb_latency got=%0d exp=153..156", n);
    drain(400);
    chk("lb_serial_tx_high", lb_bad, 0);
    chk("lb_errs", {parity_err, framing_err, overrun_err}, 0);
    lb_watch = 1'b0;
    cfg_loopback = 1'b0;

    // TX framing 8E2 at baud_div=1, looped externally into RX
    baud_div = 16'd1;
    cfg_parity_en = 1'b1;
    cfg_stop2 = 1'b1;
    link = 1'b1;
    q.push_back(8'h3C);
    push_tx(8'h3C);
    n = 0;
    while (serial_tx && n < 100) begin
      cyc(1);
      n++;
    end
    chk("tx_start_seen", serial_tx, 0);
    fb = {1'b1, 1'b1, 1'b0, 8'h3C, 1'b0};
    cyc(16);
    for (int k = 0; k < 12; k++) begin
      if (serial_tx !== fb[k]) $display("FAIL tx_bit%0d got=%b exp=%b", k, serial_tx, fb[k]);
      chk("tx_frame_bit", serial_tx, fb[k]);
      if (k < 11) cyc(32);
    end
    chk("tx_busy_in_stop2", tx_busy, 1);
    cyc(22);
    chk("tx_busy_after", tx_busy, 0);
    chk("tx_idle_line", serial_tx, 1);
    drain(1000);
    chk("frame_errs", {parity_err, framing_err, overrun_err}, 0);
    baud_div = '0;
    cfg_parity_en = 1'b0;
    cfg_stop2 = 1'b0;
    link = 1'b0;

    // burst into the TX FIFO while the first frame is in flight
    cfg_loopback = 1'b1;
    acc = 0;
    tx_data = 8'h10;
    tx_valid = 1'b1;
    while (tx_ready && acc < 20) begin
      q.push_back(tx_data);
      cyc(1);
      acc++;
      tx_data = 8'h10 + 8'(acc);
    end
    cyc(1);
    tx_valid = 1'b0;
    chk("burst_accepted", acc, 17);
    chk("burst_tx_ready_low", tx_ready, 0);
    drain(3200);

    // overrun with the consumer stalled
    rx_ready = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      if (i <= 16) q.push_back(8'(i));
      push_tx(8'(i));
    end
    n = 0;
    while ((tx_busy || rx_busy) && n < 4000) begin
      cyc(1);
      n++;
    end
    chk("ovr_link_idle", {tx_busy, rx_busy}, 0);
    chk("ovr_flag", overrun_err, 1);
    chk("ovr_head", rx_data, 8'h01);
    chk("ovr_other_errs", {parity_err, framing_err}, 0);
    clr_err();
    chk("ovr_cleared", overrun_err, 0);
    rx_ready = 1'b1;
    drain(100);
    cfg_loopback = 1'b0;

    // errors injected on serial_rx
    cfg_parity_en = 1'b1;
    cfg_parity_odd = 1'b1;
    q.push_back(8'h01);
    send_bits({1'b1, 1'b1, 8'h01, 1'b0}, 11);
    cyc(20);
    chk("par_err_set", parity_err, 1);
    chk("par_no_frame_err", framing_err, 0);
    chk("par_word_popped", q.size(), 0);
    clr_err();
    chk("par_err_cleared", parity_err, 0);
    send_bits({1'b0, 1'b1, 8'h55, 1'b0}, 11);
    cyc(20);
    chk("frm_err_set", framing_err, 1);
    chk("frm_no_par_err", parity_err, 0);
    chk("frm_nothing_pushed", rx_valid, 0);
    clr_err();
    chk("frm_err_cleared", framing_err, 0);
    rx_drv = 1'b0;
    cyc(4);
    rx_drv = 1'b1;
    cyc(40);
    chk("glitch_no_push", rx_valid, 0);
    chk("glitch_rx_idle", rx_busy, 0);
    chk("glitch_no_flags", {parity_err, framing_err, overrun_err}, 0);
    cfg_parity_en = 1'b0;
    cfg_parity_odd = 1'b0;

    // asynchronous reset in the middle of a frame
    push_tx(8'h5A);
    cyc(40);
    chk("mid_tx_busy", tx_busy, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_serial_tx", serial_tx, 1);
    chk("mid_rst_tx_busy", tx_busy, 0);
    chk("mid_rst_tx_ready", tx_ready, 1);
    cyc(2);
    rst = 1'b1;
    cyc(2);
    chk("post_rst_rx_empty", rx_valid, 0);
    cfg_loopback = 1'b1;
    q.push_back(8'h96);
    push_tx(8'h96);
    drain(400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
